// File: rtl/poly_pingpong_mem.sv
// -----------------------------------------------------------------------------
// poly_pingpong_mem
//
// Two-bank ping-pong coefficient store for the SNTRUP757 datapath. A producer
// fills one bank with sparse indexed writes while a consumer reads the other.
// Banks swap through wr_done / rd_done handshakes. With CLEAR_ON_RELEASE=1 a
// released bank is zeroed by an internal clear engine (one bank at a time,
// one word per cycle), so producers only write non-zero coefficients.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-high reset
//   wr_en     write strobe into the current write bank
//   wr_addr   write address
//   wr_data   write data
//   wr_done   producer finished the current write bank
//   wr_ready  current write bank is EMPTY and may be written
//   rd_addr   read address into the current read bank
//   rd_data   read data (0 for rd_addr >= DEPTH)
//   rd_valid  current read bank is FULL
//   rd_done   consumer releases the current read bank
//   clr_busy  clear engine active
//   err       sticky protocol errors: [0] write/done while !wr_ready,
//             [1] write address out of range, [2] rd_done while !rd_valid
// -----------------------------------------------------------------------------
module poly_pingpong_mem #(
  parameter int DATA_W           = 13,
  parameter int ADDR_W           = 11,
  parameter int DEPTH            = 757,
  parameter int REG_OUT          = 1,
  parameter int CLEAR_ON_RELEASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_done,
  output logic              clr_busy,
  output logic [2:0]        err
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_PEND,   // released, waiting for the clear engine
    ST_CLEAR   // being zeroed by the clear engine
  } bank_state_t;

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bank_state_t       state_q [2];
  bank_state_t       state_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [2:0]        err_q, err_d;

  logic [DATA_W-1:0] mem0 [2**ADDR_W];
  logic [DATA_W-1:0] mem1 [2**ADDR_W];

  logic wr_addr_ok, rd_addr_ok;
  logic clearing, clr_bank, clr_last;
  logic do_write, do_fill, do_rel;

  assign wr_ready   = (state_q[wr_ptr_q] == ST_EMPTY);
  assign rd_valid   = (state_q[rd_ptr_q] == ST_FULL);
  assign wr_addr_ok = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_addr_ok = ({1'b0, rd_addr} < DEPTH_W);

  // At most one bank is ever in CLEAR, so the engine target is simply that bank.
  assign clearing = (state_q[0] == ST_CLEAR) || (state_q[1] == ST_CLEAR);
  assign clr_bank = (state_q[1] == ST_CLEAR);
  assign clr_last = clearing && (clr_cnt_q == LAST_ADDR);
  assign clr_busy = clearing;

  assign do_write = wr_en && wr_ready && wr_addr_ok;
  assign do_fill  = wr_done && wr_ready;
  assign do_rel   = rd_done && rd_valid;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    err_d      = err_q | {rd_done && !rd_valid,
                          wr_en && !wr_addr_ok,
                          (wr_en || wr_done) && !wr_ready};

    if (clearing) begin
      if (clr_last) begin
        state_d[clr_bank] = ST_EMPTY;
        clr_cnt_d         = '0;
        // A waiting bank starts on the same edge, so clr_busy never dips.
        if (state_q[~clr_bank] == ST_PEND) state_d[~clr_bank] = ST_CLEAR;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end

    // Fill and release always target different banks (EMPTY vs FULL).
    if (do_fill) begin
      state_d[wr_ptr_q] = ST_FULL;
      wr_ptr_d          = ~wr_ptr_q;
    end

    if (do_rel) begin
      rd_ptr_d = ~rd_ptr_q;
      if (CLEAR_ON_RELEASE == 0) begin
        state_d[rd_ptr_q] = ST_EMPTY;
      end else if (!clearing || clr_last) begin
        // Engine is free, or frees up on this very edge: start immediately
        // instead of parking in PEND where nothing would ever pick it up.
        state_d[rd_ptr_q] = ST_CLEAR;
        clr_cnt_d         = '0;
      end else begin
        state_d[rd_ptr_q] = ST_PEND;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RELEASE != 0) begin
        state_q[0] <= ST_CLEAR;
        state_q[1] <= ST_PEND;
      end else begin
        state_q[0] <= ST_EMPTY;
        state_q[1] <= ST_EMPTY;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      clr_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;

  // Per-bank write port, muxed between the clear engine and the producer.
  // The two never collide: the producer only writes an EMPTY bank.
  logic              clr_we0, clr_we1, we0, we1;
  logic [ADDR_W-1:0] waddr0, waddr1;
  logic [DATA_W-1:0] wdata0, wdata1;

  assign clr_we0 = clearing && !clr_bank;
  assign clr_we1 = clearing &&  clr_bank;
  assign we0     = clr_we0 || (do_write && !wr_ptr_q);
  assign we1     = clr_we1 || (do_write &&  wr_ptr_q);
  assign waddr0  = clr_we0 ? clr_cnt_q : wr_addr;
  assign waddr1  = clr_we1 ? clr_cnt_q : wr_addr;
  assign wdata0  = clr_we0 ? '0 : wr_data;
  assign wdata1  = clr_we1 ? '0 : wr_data;

  // NOTE: the storage arrays have no reset; zeroing is the clear engine's job,
  // which keeps them mappable to distributed RAM.
  always_ff @(posedge clk) begin
    if (we0) mem0[waddr0] <= wdata0;
    if (we1) mem1[waddr1] <= wdata1;
  end

  logic [DATA_W-1:0] rd_comb;
  assign rd_comb = !rd_addr_ok ? '0 : (rd_ptr_q ? mem1[rd_addr] : mem0[rd_addr]);

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rd_comb;
      end
      assign rd_data = rd_q;
    end else begin : g_comb_out
      assign rd_data = rd_comb;
    end
  endgenerate

endmodule
